tdc_hit_arbiter: RTL and testbench

Round-robin readout arbiter that shares a single output port among `N_CH` ETROC2 TDC channels. Each channel has a one-entry holding buffer that captures the channel's encoded TOA/TOT/Cal words and error flags on its hit strobe. A fair round-robin scheduler drains these buffers into a registered valid/ready output stream toward the pixel readout logic. Hits that arrive while a channel's buffer is still occupied are dropped, and the drops are counted.

---
 rtl/tdc_hit_arbiter.sv | 151 +++++++++++++++
 tb/tb_tdc_hit_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdc_hit_arbiter.sv
// tdc_hit_arbiter: round-robin readout of N_CH TDC channels onto one
// registered valid/ready stream. Each channel owns a one-entry buffer;
// hits landing on an occupied buffer are dropped and counted.

// One-entry holding buffer for a single TDC channel.
module tdc_hit_slot (
   input  logic        clk40,
   input  logic        reset,
   input  logic        enable,
   input  logic        hit,
   input  logic        grant,
   input  logic [31:0] dataIn,
   output logic        pend,
   output logic        drop,
   output logic [31:0] data
);
   logic capture;

   // A buffer being drained this cycle counts as free, so a hit on the
   // granted channel refills it instead of being dropped.
   assign capture = enable & hit & (~pend | grant);
   assign drop    = enable & hit & pend & ~grant;

   // Capture wins over grant so a same-cycle refill keeps pend set.
   always_ff @(posedge clk40) begin
      if (reset) begin
         pend <= 1'b0;
         data <= '0;
      end else if (capture) begin
         pend <= 1'b1;
         data <= dataIn;
      end else if (grant) begin
         pend <= 1'b0;
      end
   end
endmodule

module tdc_hit_arbiter #(
   parameter int N_CH = 4,
   parameter int CH_W = $clog2(N_CH)
) (
   input  logic               clk40,
   input  logic               reset,
   input  logic               enable,
   input  logic [N_CH-1:0]    hit_i,
   input  logic [N_CH*10-1:0] toa_i,
   input  logic [N_CH*9-1:0]  tot_i,
   input  logic [N_CH*10-1:0] cal_i,
   input  logic [N_CH*3-1:0]  err_i,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [CH_W-1:0]    out_ch,
   output logic [9:0]         out_toa,
   output logic [8:0]         out_tot,
   output logic [9:0]         out_cal,
   output logic [2:0]         out_err,
   output logic [15:0]        drop_cnt,
   input  logic               drop_clr
);
   logic [N_CH-1:0]       pend;
   logic [N_CH-1:0]       grantVec;
   logic [N_CH-1:0]       dropVec;
   logic [N_CH-1:0][31:0] slotData;
   logic [CH_W-1:0]       ptr;
   logic [CH_W-1:0]       grantIdx;
   logic [CH_W-1:0]       scanCh;
   logic                  anyGrant;
   logic                  loadSlot;
   int                    scanIdx;
   logic [4:0]            nDrop;
   logic [16:0]           dropSum;

   for (genvar k = 0; k < N_CH; k++) begin : gSlot
      tdc_hit_slot uSlot (
         .clk40  (clk40),
         .reset  (reset),
         .enable (enable),
         .hit    (hit_i[k]),
         .grant  (grantVec[k]),
         .dataIn ({err_i[3*k +: 3], cal_i[10*k +: 10], tot_i[9*k +: 9], toa_i[10*k +: 10]}),
         .pend   (pend[k]),
         .drop   (dropVec[k]),
         .data   (slotData[k])
      );
   end

   // Output register is free when empty or being consumed this edge.
   assign loadSlot = ~out_valid | out_ready;

   // Round-robin search: first pending channel at or above ptr, wrapping.
   always_comb begin
      anyGrant = 1'b0;
      grantIdx = '0;
      scanIdx  = 0;
      scanCh   = '0;
      if (loadSlot) begin
         for (int i = 0; i < N_CH; i++) begin
            scanIdx = int'(ptr) + i;
            if (scanIdx >= N_CH) scanIdx = scanIdx - N_CH;
            scanCh = CH_W'(scanIdx);
            if (!anyGrant && pend[scanCh]) begin
               anyGrant = 1'b1;
               grantIdx = scanCh;
            end
         end
      end
   end

   // One-hot grant back to the winning buffer.
   always_comb begin
      grantVec = '0;
      if (anyGrant) grantVec[grantIdx] = 1'b1;
   end

   // Number of channels dropping a hit this cycle.
   always_comb begin
      nDrop = '0;
      for (int i = 0; i < N_CH; i++) nDrop = nDrop + 5'(dropVec[i]);
   end

   assign dropSum = {1'b0, drop_cnt} + 17'(nDrop);

   // Output stage: load on grant, go idle when nothing pending, hold on stall.
   always_ff @(posedge clk40) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_toa   <= '0;
         out_tot   <= '0;
         out_cal   <= '0;
         out_err   <= '0;
         ptr       <= '0;
      end else if (loadSlot) begin
         if (anyGrant) begin
            out_valid <= 1'b1;
            out_ch    <= grantIdx;
            {out_err, out_cal, out_tot, out_toa} <= slotData[grantIdx];
            ptr <= (grantIdx == CH_W'(N_CH - 1)) ? '0 : grantIdx + CH_W'(1);
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

   // Saturating drop counter; clear beats that cycle's increments.
   always_ff @(posedge clk40) begin
      if (reset || drop_clr) drop_cnt <= '0;
      else if (dropSum[16]) drop_cnt <= 16'hFFFF;
      else                  drop_cnt <= dropSum[15:0];
   end
endmodule

// File: tb/tb_tdc_hit_arbiter.sv
// Directed bench for tdc_hit_arbiter (N_CH = 4): vector table plus
// hand-written sequences for latency, reset and counter corners.
`timescale 1ns/1ps
module tb_tdc_hit_arbiter;
   localparam int N = 4;

   logic           clk40 = 1'b0;
   logic           reset = 1'b1;
   logic           enable = 1'b1;
   logic [N-1:0]   hit_i = '0;
   logic [N*10-1:0] toa_i = '0;
   logic [N*9-1:0]  tot_i = '0;
   logic [N*10-1:0] cal_i = '0;
   logic [N*3-1:0]  err_i = '0;
   logic           out_valid;
   logic           out_ready = 1'b1;
   logic [1:0]     out_ch;
   logic [9:0]     out_toa;
   logic [8:0]     out_tot;
   logic [9:0]     out_cal;
   logic [2:0]     out_err;
   logic [15:0]    drop_cnt;
   logic           drop_clr = 1'b0;

   int nChecks = 0;
   int nFail   = 0;

   tdc_hit_arbiter #(.N_CH(N)) dut (
      .clk40(clk40), .reset(reset), .enable(enable), .hit_i(hit_i),
      .toa_i(toa_i), .tot_i(tot_i), .cal_i(cal_i), .err_i(err_i),
      .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
      .out_toa(out_toa), .out_tot(out_tot), .out_cal(out_cal),
      .out_err(out_err), .drop_cnt(drop_cnt), .drop_clr(drop_clr)
   );

   always #5 clk40 = ~clk40;

   typedef struct {
      logic [3:0]  hit;
      logic [9:0]  base;
      logic        rdy;
      logic        en;
      logic        clr;
      logic        expV;
      logic [1:0]  expCh;
      logic [9:0]  expToa;
      logic [15:0] expDrop;
   } vec_t;

   vec_t vecs[22];

   task automatic step();
      @(posedge clk40);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Channel k gets toa = base + k; other fields are filler.
   task automatic setBase(input logic [9:0] base);
      for (int k = 0; k < N; k++) begin
         toa_i[10*k +: 10] = base + 10'(k);
         tot_i[9*k +: 9]   = 9'(base) ^ 9'(k);
         cal_i[10*k +: 10] = ~base;
         err_i[3*k +: 3]   = 3'(k);
      end
   endtask

   initial begin
      // hit, base, rdy, en, clr | valid, ch, toa, drop
      vecs[0]  = '{4'b1111, 10'h100, 1, 1, 0, 0, 2'd0, 10'h000, 16'd0};
      vecs[1]  = '{4'b0000, 10'h100, 1, 1, 0, 1, 2'd0, 10'h100, 16'd0};
      vecs[2]  = '{4'b0000, 10'h100, 1, 1, 0, 1, 2'd1, 10'h101, 16'd0};
      vecs[3]  = '{4'b0000, 10'h100, 1, 1, 0, 1, 2'd2, 10'h102, 16'd0};
      vecs[4]  = '{4'b0000, 10'h100, 1, 1, 0, 1, 2'd3, 10'h103, 16'd0};
      vecs[5]  = '{4'b1001, 10'h200, 1, 1, 0, 0, 2'd3, 10'h103, 16'd0};
      vecs[6]  = '{4'b0000, 10'h200, 1, 1, 0, 1, 2'd0, 10'h200, 16'd0};
      vecs[7]  = '{4'b0000, 10'h200, 1, 1, 0, 1, 2'd3, 10'h203, 16'd0};
      vecs[8]  = '{4'b0000, 10'h200, 1, 1, 0, 0, 2'd3, 10'h203, 16'd0};
      vecs[9]  = '{4'b0010, 10'h000, 0, 1, 0, 0, 2'd3, 10'h203, 16'd0};
      vecs[10] = '{4'b0010, 10'h001, 0, 1, 0, 1, 2'd1, 10'h001, 16'd0};
      vecs[11] = '{4'b0010, 10'h002, 0, 1, 0, 1, 2'd1, 10'h001, 16'd1};
      vecs[12] = '{4'b0000, 10'h002, 0, 1, 0, 1, 2'd1, 10'h001, 16'd1};
      vecs[13] = '{4'b0000, 10'h002, 1, 1, 0, 1, 2'd1, 10'h002, 16'd1};
      vecs[14] = '{4'b0000, 10'h002, 1, 1, 0, 0, 2'd1, 10'h002, 16'd1};
      vecs[15] = '{4'b0001, 10'h050, 1, 1, 0, 0, 2'd1, 10'h002, 16'd1};
      vecs[16] = '{4'b0001, 10'h3FF, 1, 1, 0, 1, 2'd0, 10'h050, 16'd1};
      vecs[17] = '{4'b0000, 10'h3FF, 1, 1, 0, 1, 2'd0, 10'h3FF, 16'd1};
      vecs[18] = '{4'b0000, 10'h3FF, 1, 1, 0, 0, 2'd0, 10'h3FF, 16'd1};
      vecs[19] = '{4'b1111, 10'h111, 1, 0, 0, 0, 2'd0, 10'h3FF, 16'd1};
      vecs[20] = '{4'b0000, 10'h111, 1, 1, 0, 0, 2'd0, 10'h3FF, 16'd1};
      vecs[21] = '{4'b0000, 10'h111, 1, 1, 1, 0, 2'd0, 10'h3FF, 16'd0};

      // Reset state
      step();
      reset = 1'b0;
      chk("rst valid", 32'(out_valid), 0);
      chk("rst ch",    32'(out_ch),    0);
      chk("rst toa",   32'(out_toa),   0);
      chk("rst tot",   32'(out_tot),   0);
      chk("rst cal",   32'(out_cal),   0);
      chk("rst err",   32'(out_err),   0);
      chk("rst drop",  32'(drop_cnt),  0);

      // Single hit on ch2: output appears exactly two edges later, one cycle wide
      toa_i[29:20] = 10'h155;
      tot_i[26:18] = 9'h0AA;
      cal_i[29:20] = 10'h2F0;
      err_i[8:6]   = 3'b001;
      hit_i = 4'b0100;
      step();
      hit_i = '0;
      chk("single lat1 valid", 32'(out_valid), 0);
      step();
      chk("single valid", 32'(out_valid), 1);
      chk("single ch",    32'(out_ch),    2);
      chk("single toa",   32'(out_toa),   32'h155);
      chk("single tot",   32'(out_tot),   32'h0AA);
      chk("single cal",   32'(out_cal),   32'h2F0);
      chk("single err",   32'(out_err),   1);
      chk("single drop",  32'(drop_cnt),  0);
      step();
      chk("single after valid", 32'(out_valid), 0);

      // Fresh reset so the table starts from ptr = 0
      reset = 1'b1;
      step();
      reset = 1'b0;

      for (int v = 0; v < 22; v++) begin
         hit_i     = vecs[v].hit;
         setBase(vecs[v].base);
         out_ready = vecs[v].rdy;
         enable    = vecs[v].en;
         drop_clr  = vecs[v].clr;
         step();
         chk($sformatf("v%0d valid", v), 32'(out_valid), 32'(vecs[v].expV));
         chk($sformatf("v%0d ch", v),    32'(out_ch),    32'(vecs[v].expCh));
         chk($sformatf("v%0d toa", v),   32'(out_toa),   32'(vecs[v].expToa));
         chk($sformatf("v%0d drop", v),  32'(drop_cnt),  32'(vecs[v].expDrop));
      end
      drop_clr = 1'b0;

      // Reset mid-operation with three channels pending under stall
      out_ready = 1'b0;
      setBase(10'h020);
      hit_i = 4'b0111;
      step();
      step();
      chk("midrst stall valid", 32'(out_valid), 1);
      chk("midrst stall ch",    32'(out_ch),    1);
      chk("midrst drops",       32'(drop_cnt),  2);
      hit_i = 4'b1111;
      reset = 1'b1;
      step();
      reset = 1'b0;
      hit_i = '0;
      out_ready = 1'b1;
      chk("midrst valid", 32'(out_valid), 0);
      chk("midrst ch",    32'(out_ch),    0);
      chk("midrst toa",   32'(out_toa),   0);
      chk("midrst tot",   32'(out_tot),   0);
      chk("midrst cal",   32'(out_cal),   0);
      chk("midrst err",   32'(out_err),   0);
      chk("midrst drop",  32'(drop_cnt),  0);
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("midrst quiet%0d", i), 32'(out_valid), 0);
      end

      // Saturation: 3 drops on the grant cycle, then 4 per stalled cycle
      out_ready = 1'b0;
      hit_i = 4'b1111;
      step();
      step();
      chk("sat first", 32'(drop_cnt), 3);
      for (int i = 0; i < 1000; i++) step();
      chk("sat mid", 32'(drop_cnt), 4003);
      for (int i = 0; i < 15400; i++) step();
      chk("sat full", 32'(drop_cnt), 32'hFFFF);
      drop_clr = 1'b1;
      step();
      drop_clr = 1'b0;
      chk("clr with drop", 32'(drop_cnt), 0);
      enable = 1'b0;
      step();
      chk("disabled hit", 32'(drop_cnt), 0);
      enable = 1'b1;
      hit_i = '0;
      step();
      chk("idle drop", 32'(drop_cnt), 0);
      hit_i = 4'b1111;
      step();
      hit_i = '0;
      chk("resume count", 32'(drop_cnt), 4);
      chk("stall held", 32'(out_valid), 1);

      // Disabled hit on an empty arbiter captures nothing
      reset = 1'b1;
      step();
      reset = 1'b0;
      out_ready = 1'b1;
      enable = 1'b0;
      hit_i = 4'b1111;
      step();
      hit_i = '0;
      enable = 1'b1;
      step();
      step();
      chk("disabled no out", 32'(out_valid), 0);
      chk("disabled no cnt", 32'(drop_cnt),  0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end
endmodule
